// File: rtl/pulse_trig_seq_pkg.sv
// Shared types and constants for the pulse_gen trigger sequencer.
package pulse_trig_seq_pkg;

  localparam int unsigned INTERVAL_W = 6;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_FIRE  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with a zero flag; shared by the DELAY and GAP phases.
module seq_down_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/pulse_trig_seq.sv
// Burst trigger sequencer: start delay, clamped trig period, burst count, abort.
module pulse_trig_seq
  import pulse_trig_seq_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PERIOD_W-1:0]   cfg_delay,
  input  logic [PERIOD_W-1:0]   cfg_period,
  input  logic [COUNT_W-1:0]    cfg_count,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  output logic                  trig,
  output logic [INTERVAL_W-1:0] interval,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    fired_cnt
);

  state_e                state_q, state_d;
  logic                  trig_q, trig_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [COUNT_W-1:0]    fired_cnt_q, fired_cnt_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [PERIOD_W-1:0]   period_s_q, period_s_d;
  logic [COUNT_W-1:0]    count_s_q, count_s_d;

  logic                  cnt_load;
  logic                  cnt_dec;
  logic [PERIOD_W-1:0]   cnt_load_val;
  logic                  cnt_zero_c;
  logic [COUNT_W-1:0]    fired_inc_c;

  assign fired_inc_c = fired_cnt_q + COUNT_W'(1);

  seq_down_cnt #(.W(PERIOD_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero_c   (cnt_zero_c)
  );

  // Next state; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    fired_cnt_d  = fired_cnt_q;
    interval_d   = interval_q;
    period_s_d   = period_s_q;
    count_s_d    = count_s_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          period_s_d  = (cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period;
          count_s_d   = cfg_count;
          interval_d  = cfg_interval;
          fired_cnt_d = '0;
          if (cfg_count == '0) begin
            done_d = 1'b1;
          end else if (cfg_delay == '0) begin
            state_d = ST_FIRE;
          end else begin
            state_d      = ST_DELAY;
            cnt_load     = 1'b1;
            cnt_load_val = cfg_delay - PERIOD_W'(1);
          end
        end
      end
      ST_DELAY, ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero_c) begin
          state_d = ST_FIRE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FIRE: begin
        // The strobe in this cycle counts even when aborted.
        fired_cnt_d = fired_inc_c;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fired_inc_c == count_s_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d      = ST_GAP;
          cnt_load     = 1'b1;
          cnt_load_val = period_s_q - PERIOD_W'(MIN_PERIOD);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    trig_d = (state_d == ST_FIRE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fired_cnt_q <= '0;
      interval_q  <= '0;
      period_s_q  <= PERIOD_W'(MIN_PERIOD);
      count_s_q   <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fired_cnt_q <= fired_cnt_d;
      interval_q  <= interval_d;
      period_s_q  <= period_s_d;
      count_s_q   <= count_s_d;
    end
  end

  assign trig      = trig_q;
  assign interval  = interval_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fired_cnt = fired_cnt_q;

endmodule

// File: tb/tb_pulse_trig_seq.sv
// Random and directed bench for pulse_trig_seq against a burst-schedule model.
module tb_pulse_trig_seq;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned IW       = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [PERIOD_W-1:0] cfg_delay = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic [COUNT_W-1:0]  cfg_count = '0;
  logic [IW-1:0]       cfg_interval = '0;
  logic                trig;
  logic [IW-1:0]       interval;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  fired_cnt;

  always #5 clk = ~clk;

  pulse_trig_seq #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_delay    (cfg_delay),
    .cfg_period   (cfg_period),
    .cfg_count    (cfg_count),
    .cfg_interval (cfg_interval),
    .trig         (trig),
    .interval     (interval),
    .busy         (busy),
    .done         (done),
    .fired_cnt    (fired_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a burst is a schedule of trig cycles first + i*P, i < N.
  longint cyc = 0;
  bit     m_valid = 0;
  bit     m_busy = 0;
  longint m_next = 0;
  int     m_left = 0;
  int     m_p = 2;
  int     m_fired = 0;
  int     m_interval = 0;
  bit     m_trig = 0;
  bit     m_done = 0;

  always @(posedge clk) begin
    bit prev_trig;
    bit was_busy;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_fired = 0; m_interval = 0; m_trig = 0; m_done = 0;
    end else begin
      prev_trig = m_trig;
      was_busy  = m_busy;
      m_trig = 0;
      m_done = 0;
      if (prev_trig) m_fired++;
      if (was_busy) begin
        if (abort) m_busy = 0;
        else if (prev_trig && m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (start && !abort) begin
        m_fired    = 0;
        m_interval = int'(cfg_interval);
        if (cfg_count == 0) m_done = 1;
        else begin
          m_busy = 1;
          m_left = int'(cfg_count);
          m_p    = (cfg_period < 2) ? 2 : int'(cfg_period);
          m_next = cyc + 1 + longint'(cfg_delay);
        end
      end
      if (m_busy && (cyc + 1 == m_next)) begin
        m_trig = 1;
        m_left--;
        m_next += m_p;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("trig", 64'(trig), 64'(m_trig));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("fired_cnt", 64'(fired_cnt), 64'(m_fired));
      chk("interval", 64'(interval), 64'(m_interval));
    end
  end

  task automatic scramble_cfg();
    cfg_delay    = PERIOD_W'($urandom_range(0, 6));
    cfg_period   = PERIOD_W'($urandom_range(0, 6));
    cfg_count    = COUNT_W'($urandom_range(0, 5));
    cfg_interval = IW'($urandom);
  endtask

  // One-cycle start with the given config, then garble cfg to show it was latched.
  task automatic kick(input int d, input int p, input int n, input int iv);
    cfg_delay    = PERIOD_W'(d);
    cfg_period   = PERIOD_W'(p);
    cfg_count    = COUNT_W'(n);
    cfg_interval = IW'(iv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic burst, then delay with clamped period
    kick(0, 5, 3, 4);
    idle(15);
    chk("basic_fired", 64'(fired_cnt), 64'd3);
    chk("basic_interval_held", 64'(interval), 64'd4);
    kick(3, 1, 2, 9);
    idle(10);
    chk("clamp_fired", 64'(fired_cnt), 64'd2);

    // Abort one cycle after the second trig
    kick(0, 10, 5, 7);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (fired_cnt == 2) seen = 1;
      else @(negedge clk);
    end
    chk("abort_wait_timeout", 64'(seen), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(30);
    chk("abort_fired", 64'(fired_cnt), 64'd2);

    // Zero count, start+abort together, start while busy
    kick(0, 3, 0, 5);
    idle(3);
    abort = 1'b1;
    kick(0, 3, 2, 1);
    abort = 1'b0;
    idle(3);
    kick(2, 4, 3, 12);
    idle(2);
    kick(0, 2, 5, 33);
    idle(20);
    chk("busy_start_fired", 64'(fired_cnt), 64'd3);

    // Reset mid-gap, then a fresh burst
    kick(0, 8, 4, 20);
    idle(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kick(0, 5, 3, 4);
    idle(15);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      scramble_cfg();
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
